// File: rtl/add_seq_if.sv
// add_seq bus bundle: operand input port, adder control, result output port.
// slave is the sequencer's view, master is the surrounding environment's view.
interface add_seq_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         add_start;
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic [W-1:0] add_z;
  logic         add_done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic         out_err;

  modport slave (
    input  in_valid, in_x, in_y,
    input  add_z, add_done,
    input  out_ready,
    output in_ready,
    output add_start, add_x, add_y,
    output out_valid, out_z, out_err
  );

  modport master (
    output in_valid, in_x, in_y,
    output add_z, add_done,
    output out_ready,
    input  in_ready,
    input  add_start, add_x, add_y,
    input  out_valid, out_z, out_err
  );
endinterface

// File: rtl/add_seq.sv
// Operand sequencer / result collector around the serial adder.
// One op in flight; done-watchdog turns a hung adder into an error result.
module add_seq #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  add_seq_if.slave   bus,
  output logic       busy,
  output logic [7:0] ops_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t       state_q;
  logic         start_q;
  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic         valid_q;
  logic [W-1:0] z_q;
  logic         err_q;
  logic         busy_q;
  logic [7:0]   ops_q;
  logic [7:0]   wdog_q;
  logic         accept;

  // A done still high from the last op must not be mistaken for this one.
  assign bus.in_ready = (state_q == IDLE) && !bus.add_done;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.add_start = start_q;
  assign bus.add_x     = x_q;
  assign bus.add_y     = y_q;
  assign bus.out_valid = valid_q;
  assign bus.out_z     = z_q;
  assign bus.out_err   = err_q;
  assign busy          = busy_q;
  assign ops_cnt       = ops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      z_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ops_q   <= 8'd0;
      wdog_q  <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q     <= bus.in_x;
            y_q     <= bus.in_y;
            start_q <= 1'b1;
            wdog_q  <= 8'd0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // done is tested first so it wins a tie with the timeout edge
          if (bus.add_done) begin
            z_q     <= bus.add_z;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else if (wdog_q == WD_LAST) begin
            z_q     <= '0;
            err_q   <= 1'b1;
            start_q <= 1'b0;
            valid_q <= 1'b1;
            wdog_q  <= wdog_q + 8'd1;
            state_q <= OUT;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (!err_q) begin
              ops_q <= ops_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
